vga_dac_palette_ctrl: RTL and testbench

//  CPU-side controller for the 256-entry VGA DAC palette dual-port RAM. Decodes the PEL mask,
//  DAC read-index, write-index and DAC-data I/O registers (0x3C6..0x3C9). Sequences the R,G,B

---
 rtl/vga_dac_palette_ctrl.sv | 162 ++++++++++++++++
 tb/tb_vga_dac_palette_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_dac_palette_ctrl.sv
// rtl/vga_dac_palette_ctrl.sv - CPU-side VGA DAC palette register controller (3C6..3C9)
module vga_dac_palette_ctrl #(
  parameter int DAC_BITS = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_sel,
  input  logic       io_we,
  input  logic [1:0] io_addr,
  input  logic [7:0] io_din,
  output logic [7:0] io_dout,
  output logic       io_ack,
  output logic [9:0] pal_ada,
  output logic [7:0] pal_dina,
  output logic       pal_cea,
  output logic       pal_wrea,
  input  logic [7:0] pal_douta,
  output logic [7:0] pel_mask
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_DATA  = 3'd1,
    RD_ISSUE = 3'd2,
    RD_CAPT  = 3'd3,
    ACK      = 3'd4
  } state_t;

  localparam logic [1:0] A_MASK  = 2'd0;
  localparam logic [1:0] A_RIDX  = 2'd1;
  localparam logic [1:0] A_WIDX  = 2'd2;
  localparam logic [1:0] A_DATA  = 2'd3;

  state_t     state;
  logic [7:0] windex;
  logic [7:0] rindex;
  logic [1:0] comp;
  logic       mode_read;

  // Narrow a colour byte to the stored component width (6-bit DACs keep the top bits clear)
  function automatic logic [7:0] dac_mask(input logic [7:0] v);
    if (DAC_BITS == 6) return {2'b00, v[5:0]};
    else               return v;
  endfunction

  // Single FSM: register decode, R/G/B sequencing and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      io_ack    <= 1'b0;
      io_dout   <= 8'h00;
      pal_cea   <= 1'b0;
      pal_wrea  <= 1'b0;
      pal_ada   <= 10'h000;
      pal_dina  <= 8'h00;
      pel_mask  <= 8'hFF;
      windex    <= 8'h00;
      rindex    <= 8'h00;
      comp      <= 2'd0;
      mode_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          io_ack   <= 1'b0;
          pal_cea  <= 1'b0;
          pal_wrea <= 1'b0;
          if (io_sel) begin
            case (io_addr)
              A_DATA: begin
                if (io_we) begin
                  // Write is issued and acknowledged in the same cycle
                  state    <= WR_DATA;
                  pal_cea  <= 1'b1;
                  pal_wrea <= 1'b1;
                  pal_ada  <= {windex, comp};
                  pal_dina <= dac_mask(io_din);
                  io_ack   <= 1'b1;
                end else begin
                  state   <= RD_ISSUE;
                  pal_cea <= 1'b1;
                  pal_ada <= {rindex, comp};
                end
              end
              A_MASK: begin
                if (io_we) pel_mask <= io_din;
                else       io_dout  <= pel_mask;
                state  <= ACK;
                io_ack <= 1'b1;
              end
              A_RIDX: begin
                if (io_we) begin
                  rindex    <= io_din;
                  comp      <= 2'd0;
                  mode_read <= 1'b1;
                end else begin
                  io_dout <= mode_read ? 8'h03 : 8'h00;
                end
                state  <= ACK;
                io_ack <= 1'b1;
              end
              default: begin
                if (io_we) begin
                  windex    <= io_din;
                  comp      <= 2'd0;
                  mode_read <= 1'b0;
                end else begin
                  io_dout <= windex;
                end
                state  <= ACK;
                io_ack <= 1'b1;
              end
            endcase
          end
        end

        WR_DATA: begin
          io_ack   <= 1'b0;
          pal_cea  <= 1'b0;
          pal_wrea <= 1'b0;
          if (comp == 2'd2) begin
            comp   <= 2'd0;
            windex <= windex + 8'd1;
          end else begin
            comp <= comp + 2'd1;
          end
          state <= IDLE;
        end

        RD_ISSUE: begin
          // RAM latches the address on this edge; data is available next cycle
          pal_cea <= 1'b0;
          state   <= RD_CAPT;
        end

        RD_CAPT: begin
          io_dout <= dac_mask(pal_douta);
          io_ack  <= 1'b1;
          if (comp == 2'd2) begin
            comp   <= 2'd0;
            rindex <= rindex + 8'd1;
          end else begin
            comp <= comp + 2'd1;
          end
          state <= ACK;
        end

        ACK: begin
          io_ack <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          io_ack   <= 1'b0;
          pal_cea  <= 1'b0;
          pal_wrea <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_dac_palette_ctrl.sv
// tb/tb_vga_dac_palette_ctrl.sv - self-checking bench for vga_dac_palette_ctrl (6- and 8-bit builds)
`timescale 1ns/1ps
module tb_vga_dac_palette_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       we = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [7:0] din = 8'h00;
  logic       ram_clr = 1'b0;

  logic [7:0] dout6, dout8, dina6, dina8, douta6, douta8, mask6, mask8;
  logic       ack6, ack8, cea6, cea8, wrea6, wrea8;
  logic [9:0] ada6, ada8;

  logic [7:0] ram6 [0:1023];
  logic [7:0] ram8 [0:1023];
  logic [9:0] last_wa;
  int         wr_cnt = 0;
  int         ack_cnt = 0;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] m_mask;
  int         m_widx, m_ridx, m_comp;
  bit         m_read_mode;
  logic [7:0] m_pal [0:1023];

  always #5 clk = ~clk;

  vga_dac_palette_ctrl #(.DAC_BITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .io_sel(sel), .io_we(we), .io_addr(addr), .io_din(din),
    .io_dout(dout6), .io_ack(ack6), .pal_ada(ada6), .pal_dina(dina6), .pal_cea(cea6),
    .pal_wrea(wrea6), .pal_douta(douta6), .pel_mask(mask6)
  );

  vga_dac_palette_ctrl #(.DAC_BITS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .io_sel(sel), .io_we(we), .io_addr(addr), .io_din(din),
    .io_dout(dout8), .io_ack(ack8), .pal_ada(ada8), .pal_dina(dina8), .pal_cea(cea8),
    .pal_wrea(wrea8), .pal_douta(douta8), .pel_mask(mask8)
  );

  // palette RAM models: byte port, synchronous read
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) begin
        ram6[i] <= 8'h00;
        ram8[i] <= 8'h00;
      end
    end else begin
      if (cea6) begin
        if (wrea6) begin
          ram6[ada6] <= dina6;
          last_wa    <= ada6;
          wr_cnt     <= wr_cnt + 1;
        end
        douta6 <= ram6[ada6];
      end
      if (cea8) begin
        if (wrea8) ram8[ada8] <= dina8;
        douta8 <= ram8[ada8];
      end
    end
  end

  always @(posedge clk) if (ack6) ack_cnt <= ack_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mask = 8'hFF;
    m_widx = 0;
    m_ridx = 0;
    m_comp = 0;
    m_read_mode = 0;
    for (int i = 0; i < 1024; i++) m_pal[i] = 8'h00;
  endtask

  // one CPU access: predict from the model, run it on both builds, compare
  task automatic run_op(input bit w, input logic [1:0] a, input logic [7:0] d, input string tag);
    int         exp_lat, lat, ba;
    logic [7:0] exp6, exp8;
    exp_lat = 1; exp6 = 8'h00; exp8 = 8'h00; ba = 0;
    case (a)
      2'd0: if (w) m_mask = d; else begin exp6 = m_mask; exp8 = m_mask; end
      2'd1: if (w) begin m_ridx = d; m_comp = 0; m_read_mode = 1; end
            else begin exp6 = m_read_mode ? 8'h03 : 8'h00; exp8 = exp6; end
      2'd2: if (w) begin m_widx = d; m_comp = 0; m_read_mode = 0; end
            else begin exp6 = m_widx[7:0]; exp8 = exp6; end
      default: begin
        if (w) begin
          ba = m_widx * 4 + m_comp;
          m_pal[ba] = d;
          m_comp = (m_comp + 1) % 3;
          if (m_comp == 0) m_widx = (m_widx + 1) % 256;
        end else begin
          exp_lat = 3;
          ba = m_ridx * 4 + m_comp;
          exp8 = m_pal[ba];
          exp6 = m_pal[ba] % 64;
          m_comp = (m_comp + 1) % 3;
          if (m_comp == 0) m_ridx = (m_ridx + 1) % 256;
        end
      end
    endcase

    @(negedge clk);
    sel = 1'b1; we = w; addr = a; din = d;
    @(posedge clk); #1;
    sel = 1'b0;
    lat = 1;
    while (!ack6 && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    if (!w) begin
      chk({tag, "_dout6"}, dout6, exp6);
      chk({tag, "_dout8"}, dout8, exp8);
    end
    @(posedge clk); #1;
    chk({tag, "_ack_low"}, ack6, 1'b0);
    if (w && a == 2'd3) begin
      chk({tag, "_ram6"}, ram6[ba], d % 64);
      chk({tag, "_ram8"}, ram8[ba], d);
    end
    if (w && a == 2'd0) chk({tag, "_mask"}, mask6, d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0] wrap_a [4];
    logic [7:0] tri_d [3];
    int a0, w0;

    // ---- reset values ----
    ram_clr = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mask", mask6, 8'hFF);
    chk("rst_ack", ack6, 1'b0);
    chk("rst_dout", dout6, 8'h00);
    chk("rst_cea_wrea", {cea6, wrea6}, 2'b00);
    chk("rst_ada_dina", {ada6, dina6}, 18'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ram_clr = 1'b0;

    // ---- reset in the middle of a 3C9 read ----
    run_op(1, 2'd0, 8'h5A, "pre_mask");
    @(negedge clk);
    sel = 1'b1; we = 1'b0; addr = 2'd3;
    @(posedge clk); #1;
    sel = 1'b0;
    chk("abort_issue_cea", cea6, 1'b1);
    a0 = ack_cnt; w0 = wr_cnt;
    #2 rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_ack", ack_cnt, a0);
    chk("abort_no_write", wr_cnt, w0);
    chk("abort_cea", cea6, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    m_mask = 8'hFF; m_widx = 0; m_ridx = 0; m_comp = 0; m_read_mode = 0;
    #1;
    chk("post_rst_mask", mask6, 8'hFF);
    run_op(0, 2'd1, 8'h00, "post_rst_3c7");
    run_op(0, 2'd2, 8'h00, "post_rst_3c8");

    // ---- write triplet at index 0x10 ----
    tri_d[0] = 8'h3F; tri_d[1] = 8'h2A; tri_d[2] = 8'h15;
    run_op(1, 2'd2, 8'h10, "w_idx10");
    for (int i = 0; i < 3; i++) begin
      run_op(1, 2'd3, tri_d[i], "w_tri");
      chk("w_tri_addr", last_wa, 10'h040 + 10'(i));
    end
    run_op(0, 2'd2, 8'h00, "w_idx_after");
    chk("w_idx_is_11", m_widx, 32'h11);

    // ---- read triplet back ----
    run_op(1, 2'd1, 8'h10, "r_idx10");
    for (int i = 0; i < 3; i++) run_op(0, 2'd3, 8'h00, "r_tri");
    run_op(0, 2'd1, 8'h00, "r_state");

    // ---- index wrap on write ----
    wrap_a[0] = 10'h3FC; wrap_a[1] = 10'h3FD; wrap_a[2] = 10'h3FE; wrap_a[3] = 10'h000;
    run_op(1, 2'd2, 8'hFF, "wrap_idx");
    for (int i = 0; i < 4; i++) begin
      run_op(1, 2'd3, 8'(8'hC0 + i), "wrap_wr");
      chk("wrap_addr", last_wa, wrap_a[i]);
    end

    // ---- DAC width: 0xFF stored as 3F / FF ----
    run_op(1, 2'd2, 8'h20, "dac_widx");
    run_op(1, 2'd3, 8'hFF, "dac_wr");
    chk("dac_ram6", ram6[10'h080], 8'h3F);
    chk("dac_ram8", ram8[10'h080], 8'hFF);
    run_op(1, 2'd1, 8'h20, "dac_ridx");
    run_op(0, 2'd3, 8'h00, "dac_rd");

    // ---- strobe during RD_CAPT is dropped ----
    begin
      logic [7:0] e6, e8;
      int ba;
      ba = m_ridx * 4 + m_comp;
      e8 = m_pal[ba];
      e6 = m_pal[ba] % 64;
      m_comp = (m_comp + 1) % 3;
      if (m_comp == 0) m_ridx = (m_ridx + 1) % 256;
      @(negedge clk);
      sel = 1'b1; we = 1'b0; addr = 2'd3;
      @(posedge clk); #1;
      sel = 1'b0;
      @(posedge clk);
      @(negedge clk);
      sel = 1'b1; we = 1'b1; addr = 2'd2; din = 8'h55;
      @(posedge clk); #1;
      sel = 1'b0;
      chk("drop_ack", ack6, 1'b1);
      chk("drop_dout6", dout6, e6);
      chk("drop_dout8", dout8, e8);
      a0 = ack_cnt;
      repeat (4) @(posedge clk);
      #1;
      chk("drop_single_ack", ack_cnt, a0 + 1);
    end
    run_op(0, 2'd2, 8'h00, "drop_widx");
    run_op(0, 2'd3, 8'h00, "drop_next_rd");

    // ---- randomized mix ----
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 8);
      run_op(1'($urandom_range(0, 1)), (r < 6) ? 2'd3 : 2'(r - 6), 8'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
